cpu_fetch: RTL and testbench

- Instruction fetch unit. Sole producer for the instruction FIFO.
- Masters a 32-bit Wishbone-style read bus into instruction memory and pushes 32-bit words into the FIFO write port.
- Honours FIFO backpressure and redirects on branch/reset.
- Realigns halfword-aligned branch targets so the FIFO always receives the target halfword in bits 31:16 of its first write.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_fetch_align.sv | 44 ++++
 rtl/cpu_fetch.sv | 120 ++++++++++++
 tb/tb_cpu_fetch.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-unit types and constants
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] WORD_BYTES           = 32'd4;

endpackage

// File: rtl/cpu_fetch_align.sv
// rtl/cpu_fetch_align.sv - halfword realignment of fetched words
module cpu_fetch_align
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        misalign_set,
    output logic [31:0] out_word,
    output logic        out_valid
);

    logic        misalign;
    logic        have_h;
    logic [15:0] h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
            have_h   <= 1'b0;
            h        <= 16'h0000;
        end else if (flush) begin
            misalign <= misalign_set;
            have_h   <= 1'b0;
            h        <= 16'h0000;
        end else if (in_valid && misalign) begin
            h      <= in_word[15:0];
            have_h <= 1'b1;
        end
    end

    // The first word after a misaligned redirect only primes h.
    always_comb begin
        out_word  = in_word;
        out_valid = in_valid;
        if (misalign) begin
            out_word  = {h, in_word[31:16]};
            out_valid = in_valid && have_h;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch unit feeding the instruction FIFO
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    input  logic        fifo_full_i,
    output logic        fifo_write_en_o,
    output logic [31:0] fifo_data_o,
    input  logic        branch_p_i,
    input  logic [31:0] branch_target_i,
    output logic        newPC_p_o,
    output logic [31:0] PC_o
);

    fetch_state_t state;
    logic [31:0]  skid_data;
    logic         skid_valid;

    logic         ack_direct;
    logic         ack_to_skid;
    logic         skid_drain;
    logic         align_in_valid;
    logic [31:0]  align_in_word;
    logic [31:0]  align_out_word;
    logic         align_out_valid;
    logic         unused_target_bit;

    assign unused_target_bit = branch_target_i[0];

    // Acks are only honoured in REQ; a branch in the same cycle discards them.
    assign ack_direct     = (state == REQ) && wb_ack_i && !fifo_full_i && !branch_p_i;
    assign ack_to_skid    = (state == REQ) && wb_ack_i && fifo_full_i && !branch_p_i;
    assign skid_drain     = (state == STALL) && skid_valid && !fifo_full_i && !branch_p_i;
    assign align_in_valid = ack_direct || skid_drain;
    assign align_in_word  = skid_drain ? skid_data : wb_dat_i;

    cpu_fetch_align u_align (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .in_word      (align_in_word),
        .in_valid     (align_in_valid),
        .flush        (branch_p_i),
        .misalign_set (branch_target_i[1]),
        .out_word     (align_out_word),
        .out_valid    (align_out_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            wb_adr_o        <= {BOOT_ADDRESS[31:2], 2'b00};
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            skid_data       <= 32'h0;
            skid_valid      <= 1'b0;
            fifo_write_en_o <= 1'b0;
            fifo_data_o     <= 32'h0;
            newPC_p_o       <= 1'b0;
            PC_o            <= {BOOT_ADDRESS[31:1], 1'b0};
        end else if (branch_p_i) begin
            state           <= IDLE;
            wb_adr_o        <= {branch_target_i[31:2], 2'b00};
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            skid_valid      <= 1'b0;
            fifo_write_en_o <= 1'b0;
            newPC_p_o       <= 1'b1;
            PC_o            <= {branch_target_i[31:1], 1'b0};
        end else begin
            newPC_p_o       <= 1'b0;
            fifo_write_en_o <= align_out_valid;
            if (align_out_valid) begin
                fifo_data_o <= align_out_word;
            end
            case (state)
                IDLE: begin
                    if (!fifo_full_i && !skid_valid && !fifo_write_en_o) begin
                        state    <= REQ;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        wb_adr_o <= wb_adr_o + WORD_BYTES;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (ack_to_skid) begin
                            skid_data  <= wb_dat_i;
                            skid_valid <= 1'b1;
                            state      <= STALL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                STALL: begin
                    if (!fifo_full_i) begin
                        skid_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - cycle-vector bench for cpu_fetch
module tb_cpu_fetch;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic        fifo_full_i;
    logic        fifo_write_en_o;
    logic [31:0] fifo_data_o;
    logic        branch_p_i;
    logic [31:0] branch_target_i;
    logic        newPC_p_o;
    logic [31:0] PC_o;

    int applied = 0;
    int miscompares = 0;

    cpu_fetch #(.BOOT_ADDRESS(32'h0000_1000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .wb_adr_o        (wb_adr_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_ack_i        (wb_ack_i),
        .wb_dat_i        (wb_dat_i),
        .fifo_full_i     (fifo_full_i),
        .fifo_write_en_o (fifo_write_en_o),
        .fifo_data_o     (fifo_data_o),
        .branch_p_i      (branch_p_i),
        .branch_target_i (branch_target_i),
        .newPC_p_o       (newPC_p_o),
        .PC_o            (PC_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        full;
        logic        ack;
        logic [31:0] dat;
        logic        br;
        logic [31:0] tgt;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic        e_we;
        logic [31:0] e_data;
        logic        e_np;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(logic full, logic ack, logic [31:0] dat, logic br,
                                logic [31:0] tgt, logic cyc, logic [31:0] adr, logic we,
                                logic [31:0] data, logic np, logic [31:0] pc);
        vec_t v;
        v.full = full; v.ack = ack; v.dat = dat; v.br = br; v.tgt = tgt;
        v.e_cyc = cyc; v.e_adr = adr; v.e_we = we; v.e_data = data;
        v.e_np = np; v.e_pc = pc;
        return v;
    endfunction

    task automatic check(string name, logic cyc, logic [31:0] adr, logic we,
                         logic [31:0] data, logic np, logic [31:0] pc);
        applied++;
        if (wb_cyc_o !== cyc || wb_stb_o !== cyc) begin
            miscompares++;
            $display("FAIL %s cyc/stb: got %b/%b expected %b", name, wb_cyc_o, wb_stb_o, cyc);
        end
        if (wb_adr_o !== adr) begin
            miscompares++;
            $display("FAIL %s adr: got %h expected %h", name, wb_adr_o, adr);
        end
        if (fifo_write_en_o !== we) begin
            miscompares++;
            $display("FAIL %s write_en: got %b expected %b", name, fifo_write_en_o, we);
        end
        if (fifo_data_o !== data) begin
            miscompares++;
            $display("FAIL %s data: got %h expected %h", name, fifo_data_o, data);
        end
        if (newPC_p_o !== np) begin
            miscompares++;
            $display("FAIL %s newPC: got %b expected %b", name, newPC_p_o, np);
        end
        if (PC_o !== pc) begin
            miscompares++;
            $display("FAIL %s pc: got %h expected %h", name, PC_o, pc);
        end
    endtask

    initial begin
        // Each vector: inputs held for one cycle, outputs checked just after the edge.
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h1000, 0, 32'h0,        0, 32'h1000);
        vecs[1]  = mk(0, 1, 32'h11112222, 0, 32'h0,        0, 32'h1004, 1, 32'h11112222, 0, 32'h1000);
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h1004, 0, 32'h11112222, 0, 32'h1000);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h1004, 0, 32'h11112222, 0, 32'h1000);
        vecs[4]  = mk(1, 1, 32'hAAAA5555, 0, 32'h0,        0, 32'h1008, 0, 32'h11112222, 0, 32'h1000);
        vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 0, 32'h11112222, 0, 32'h1000);
        vecs[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 0, 32'h11112222, 0, 32'h1000);
        vecs[7]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 0, 32'h11112222, 0, 32'h1000);
        vecs[8]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 0, 32'h11112222, 0, 32'h1000);
        vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 1, 32'hAAAA5555, 0, 32'h1000);
        vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h1008, 0, 32'hAAAA5555, 0, 32'h1000);
        vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h1008, 0, 32'hAAAA5555, 0, 32'h1000);
        vecs[12] = mk(0, 1, 32'h33334444, 1, 32'h2000,     0, 32'h2000, 0, 32'hAAAA5555, 1, 32'h2000);
        vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h2000, 0, 32'hAAAA5555, 0, 32'h2000);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'h2002,     0, 32'h2000, 0, 32'hAAAA5555, 1, 32'h2002);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h2000, 0, 32'hAAAA5555, 0, 32'h2002);
        vecs[16] = mk(0, 1, 32'hAAAABBBB, 0, 32'h0,        0, 32'h2004, 0, 32'hAAAA5555, 0, 32'h2002);
        vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h2004, 0, 32'hAAAA5555, 0, 32'h2002);
        vecs[18] = mk(0, 1, 32'hCCCCDDDD, 0, 32'h0,        0, 32'h2008, 1, 32'hBBBBCCCC, 0, 32'h2002);
        vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h2008, 0, 32'hBBBBCCCC, 0, 32'h2002);
        vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h2008, 0, 32'hBBBBCCCC, 0, 32'h2002);
        vecs[21] = mk(0, 1, 32'hEEEEFFFF, 0, 32'h0,        0, 32'h200C, 1, 32'hDDDDEEEE, 0, 32'h2002);
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h200C, 0, 32'hDDDDEEEE, 0, 32'h2002);
        vecs[23] = mk(0, 0, 32'h0,        1, 32'h3000,     0, 32'h3000, 0, 32'hDDDDEEEE, 1, 32'h3000);
        vecs[24] = mk(0, 0, 32'h0,        1, 32'h4006,     0, 32'h4004, 0, 32'hDDDDEEEE, 1, 32'h4006);
        vecs[25] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4004, 0, 32'hDDDDEEEE, 0, 32'h4006);
        vecs[26] = mk(0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 32'hDDDDEEEE, 1, 32'hFFFFFFFC);
        vecs[27] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'hDDDDEEEE, 0, 32'hFFFFFFFC);
        vecs[28] = mk(0, 1, 32'h12345678, 0, 32'h0,        0, 32'h0,    1, 32'h12345678, 0, 32'hFFFFFFFC);
        vecs[29] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,    0, 32'h12345678, 0, 32'hFFFFFFFC);
        vecs[30] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,    0, 32'h12345678, 0, 32'hFFFFFFFC);

        rst_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        fifo_full_i = 1'b0;
        branch_p_i = 1'b0;
        branch_target_i = 32'h0;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset", 0, 32'h1000, 0, 32'h0, 0, 32'h1000);
        rst_i = 1'b1;

        for (int i = 0; i < 31; i++) begin
            fifo_full_i     = vecs[i].full;
            wb_ack_i        = vecs[i].ack;
            wb_dat_i        = vecs[i].dat;
            branch_p_i      = vecs[i].br;
            branch_target_i = vecs[i].tgt;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_cyc, vecs[i].e_adr, vecs[i].e_we,
                  vecs[i].e_data, vecs[i].e_np, vecs[i].e_pc);
        end

        // Reset while REQ is pending, then an ack arriving right after release.
        fifo_full_i = 1'b0;
        wb_ack_i    = 1'b0;
        branch_p_i  = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        check("async_reset", 0, 32'h1000, 0, 32'h0, 0, 32'h1000);
        @(posedge clk_i);
        #1;
        rst_i    = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        @(posedge clk_i);
        #1;
        check("stale_ack", 1, 32'h1000, 0, 32'h0, 0, 32'h1000);
        wb_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("req_after_reset", 1, 32'h1000, 0, 32'h0, 0, 32'h1000);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h55667788;
        @(posedge clk_i);
        #1;
        check("first_after_reset", 0, 32'h1004, 1, 32'h55667788, 0, 32'h1000);
        wb_ack_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
